// File: rtl/line_sequencer_pkg.sv
// ============================================================================
// line_sequencer_pkg
// Shared raster defines: pixel coordinate type, sequencer states, edge decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

package line_sequencer_pkg;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } Point2D;

  typedef enum logic [1:0] {
    LS_IDLE  = 2'd0,
    LS_ISSUE = 2'd1,
    LS_WAIT  = 2'd2,
    LS_DONE  = 2'd3
  } LineSeqState;

  localparam logic [1:0] EDGE_LINE_LAST = 2'd0;
  localparam logic [1:0] EDGE_TRI_LAST  = 2'd2;

  // Edges run v0->v1, v1->v2, v2->v0; index 3 is unreachable and aliases edge 0.
  function automatic Point2D edge_start(input logic [1:0] idx, input Point2D a,
                                        input Point2D b, input Point2D c);
    case (idx)
      2'd1:    return b;
      2'd2:    return c;
      default: return a;
    endcase
  endfunction

  function automatic Point2D edge_end(input logic [1:0] idx, input Point2D a,
                                      input Point2D b, input Point2D c);
    case (idx)
      2'd1:    return c;
      2'd2:    return a;
      default: return b;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_sequencer.sv
// ============================================================================
// line_sequencer
// Issues one Bresenham engine run per primitive edge and forwards its pixels.
// Revision: 1.0
// ============================================================================
`default_nettype none

module line_sequencer
  import line_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prim_valid,
  output logic        prim_ready,
  input  logic        prim_tri,
  input  Point2D      v0,
  input  Point2D      v1,
  input  Point2D      v2,
  output logic        le_start,
  output Point2D      le_p,
  output Point2D      le_q,
  input  logic        le_plot,
  input  Point2D      le_point,
  input  logic        le_done,
  output logic        pix_valid,
  output Point2D      pix_point,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] pix_count
);

  localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  LineSeqState     state_q;
  logic            tri_q;
  Point2D          v0_q, v1_q, v2_q;
  logic [1:0]      edge_q;
  logic [WD_W-1:0] wd_q;
  logic            prim_ready_q, busy_q, done_q, timeout_q, le_start_q;
  Point2D          le_p_q, le_q_q;
  logic [15:0]     pix_count_q, pix_count_d;
  logic [1:0]      edge_d;
  logic [1:0]      last_edge;
  logic            pix_fire;

  assign pix_fire    = le_plot && (state_q == LS_WAIT);
  assign pix_count_d = (pix_count_q == 16'hFFFF) ? pix_count_q : pix_count_q + 16'd1;
  assign edge_d      = edge_q + 2'd1;
  assign last_edge   = tri_q ? EDGE_TRI_LAST : EDGE_LINE_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LS_IDLE;
      tri_q        <= 1'b0;
      v0_q         <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      edge_q       <= 2'd0;
      wd_q         <= '0;
      prim_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      le_start_q   <= 1'b0;
      le_p_q       <= '0;
      le_q_q       <= '0;
      pix_count_q  <= 16'd0;
    end else begin
      le_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (pix_fire) pix_count_q <= pix_count_d;

      case (state_q)
        LS_IDLE: begin
          if (prim_valid) begin
            v0_q         <= v0;
            v1_q         <= v1;
            v2_q         <= v2;
            tri_q        <= prim_tri;
            edge_q       <= 2'd0;
            pix_count_q  <= 16'd0;
            timeout_q    <= 1'b0;
            // Endpoints load together with the start pulse so the engine sees them in ISSUE.
            le_p_q       <= v0;
            le_q_q       <= v1;
            le_start_q   <= 1'b1;
            prim_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= LS_ISSUE;
          end
        end
        LS_ISSUE: begin
          wd_q    <= '0;
          state_q <= LS_WAIT;
        end
        LS_WAIT: begin
          if (le_done) begin
            if (edge_q == last_edge) begin
              done_q  <= 1'b1;
              state_q <= LS_DONE;
            end else begin
              edge_q     <= edge_d;
              le_p_q     <= edge_start(edge_d, v0_q, v1_q, v2_q);
              le_q_q     <= edge_end(edge_d, v0_q, v1_q, v2_q);
              le_start_q <= 1'b1;
              state_q    <= LS_ISSUE;
            end
          end else if (wd_q == WD_LAST) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= LS_DONE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        LS_DONE: begin
          prim_ready_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= LS_IDLE;
        end
        default: state_q <= LS_IDLE;
      endcase
    end
  end

  assign prim_ready = prim_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign le_start   = le_start_q;
  assign le_p       = le_p_q;
  assign le_q       = le_q_q;
  assign pix_count  = pix_count_q;
  assign pix_valid  = pix_fire;
  assign pix_point  = le_point;

endmodule

`default_nettype wire
